// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access controller: FSM state encodings
// and wait-counter sizing.
package mem_ctrl_pkg;

  localparam int unsigned MC_STATE_W = 2;

  localparam logic [MC_STATE_W-1:0] MC_IDLE   = 2'd0;
  localparam logic [MC_STATE_W-1:0] MC_ACCESS = 2'd1;
  localparam logic [MC_STATE_W-1:0] MC_WAIT   = 2'd2;
  localparam logic [MC_STATE_W-1:0] MC_DONE   = 2'd3;

  localparam int unsigned WAIT_CNT_W = 4;

  // The counter is loaded on the strobe cycle, so it must count
  // WAIT_CYCLES-1 more edges before it reaches zero.
  function automatic logic [WAIT_CNT_W-1:0] wait_load(input int unsigned wait_cycles);
    return WAIT_CNT_W'(wait_cycles - 1);
  endfunction

endpackage

// File: rtl/mem_ctrl_wait_counter.sv
// Loadable 4-bit down-counter that measures the memory latency window.
module mem_ctrl_wait_counter
  import mem_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WAIT_CNT_W-1:0] load_value,
  input  logic                  enable,
  output logic                  zero
);

  logic [WAIT_CNT_W-1:0] count_q;

  // Load takes priority; counting saturates at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (enable && (count_q != '0)) begin
      count_q <= count_q - WAIT_CNT_W'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/mem_ctrl.sv
// Memory access controller: turns a CPU read/write request into a single
// memory strobe, waits out the fixed memory latency and returns a one-cycle
// ready pulse. Out-of-range addresses complete immediately with an error.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned BITS_DATA   = 32,
  parameter int unsigned BITS_ADDR   = 16,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned MEM_WORDS   = 65536
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [BITS_ADDR-1:0] cpu_addr,
  input  logic [BITS_DATA-1:0] cpu_wdata,
  output logic                 cpu_ready,
  output logic                 cpu_err,
  output logic [BITS_DATA-1:0] cpu_rdata,
  output logic                 busy,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [BITS_ADDR-1:0] mem_addr,
  output logic [BITS_DATA-1:0] mem_wdata,
  input  logic [BITS_DATA-1:0] mem_rdata
);

  logic [MC_STATE_W-1:0] state_q, state_d;
  logic                  we_q;
  logic                  err_q;
  logic [BITS_ADDR-1:0]  addr_q;
  logic [BITS_DATA-1:0]  wdata_q;
  logic [BITS_DATA-1:0]  rdata_q;
  logic                  cnt_zero;
  logic                  addr_ok;
  logic                  sample;

  // Unsigned compare in 32 bits so MEM_WORDS = 2^BITS_ADDR never errors.
  assign addr_ok = (32'(cpu_addr) < MEM_WORDS);
  assign sample  = (state_q == MC_IDLE) && cpu_req;

  mem_ctrl_wait_counter u_wait_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (state_q == MC_ACCESS),
    .load_value (wait_load(WAIT_CYCLES)),
    .enable     (state_q == MC_WAIT),
    .zero       (cnt_zero)
  );

  // Next-state decode for the access sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MC_IDLE:   if (cpu_req) state_d = addr_ok ? MC_ACCESS : MC_DONE;
      MC_ACCESS: state_d = MC_WAIT;
      MC_WAIT:   if (cnt_zero) state_d = MC_DONE;
      MC_DONE:   state_d = MC_IDLE;
      default:   state_d = MC_IDLE;
    endcase
  end

  // State register plus request latches and read-data capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MC_IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (sample) begin
        we_q    <= cpu_we;
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        err_q   <= !addr_ok;
      end
      if ((state_q == MC_WAIT) && cnt_zero && !we_q) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  // Outputs decoded from registered state only, so reset drops them at once.
  assign busy      = (state_q != MC_IDLE);
  assign mem_en    = (state_q == MC_ACCESS);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_ready = (state_q == MC_DONE);
  assign cpu_err   = cpu_ready && err_q;
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: table-driven transactions on a
// WAIT_CYCLES=2 / MEM_WORDS=1024 build, plus hand-written sequences for
// back-to-back requests, mid-transaction reset and the latency extremes.
module tb_mem_ctrl;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          edges;
    int          en;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  // Main DUT (WAIT_CYCLES=2, MEM_WORDS=1024).
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_ready, cpu_err, busy, mem_en, mem_we;
  logic [31:0] cpu_rdata, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [15:0] mem_addr;

  // Latency DUTs (WAIT_CYCLES=1 and 15).
  logic        req_a = 1'b0, req_b = 1'b0;
  logic        ready_a, err_a, busy_a, en_a, we_a;
  logic        ready_b, err_b, busy_b, en_b, we_b;
  logic [31:0] rdata_a, rdata_b, wdata_a, wdata_b;
  logic [15:0] addr_a, addr_b;

  // Memory model for the main DUT, with a preload port for the bench.
  logic        pre_en = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] mem [1024];

  int errors = 0;
  int checks = 0;
  vec_t vecs[7];

  int n, r1, r2, en_cnt, la, lb, ena, enb, quiet;
  logic got, saw_we, got_err;
  logic [15:0] seen_addr;

  always #5 clk = ~clk;

  mem_ctrl #(.BITS_DATA(32), .BITS_ADDR(16), .WAIT_CYCLES(2), .MEM_WORDS(1024)) u_dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_ctrl #(.BITS_DATA(32), .BITS_ADDR(16), .WAIT_CYCLES(1), .MEM_WORDS(65536)) u_w1 (
    .clk(clk), .reset(reset), .cpu_req(req_a), .cpu_we(1'b0), .cpu_addr(16'h1234),
    .cpu_wdata(32'h0000_0077), .cpu_ready(ready_a), .cpu_err(err_a), .cpu_rdata(rdata_a),
    .busy(busy_a), .mem_en(en_a), .mem_we(we_a), .mem_addr(addr_a),
    .mem_wdata(wdata_a), .mem_rdata(32'h1111_0001)
  );

  mem_ctrl #(.BITS_DATA(32), .BITS_ADDR(16), .WAIT_CYCLES(15), .MEM_WORDS(65536)) u_w15 (
    .clk(clk), .reset(reset), .cpu_req(req_b), .cpu_we(1'b0), .cpu_addr(16'hFFFF),
    .cpu_wdata(32'h0000_0088), .cpu_ready(ready_b), .cpu_err(err_b), .cpu_rdata(rdata_b),
    .busy(busy_b), .mem_en(en_b), .mem_we(we_b), .mem_addr(addr_b),
    .mem_wdata(wdata_b), .mem_rdata(32'h1515_000F)
  );

  // Synchronous memory: read data is registered on the strobe and then held.
  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[9:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 with the DUT back in IDLE.
  task automatic txn(input logic we, input logic [15:0] addr, input logic [31:0] wdata);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    n = 0; en_cnt = 0; got = 1'b0; saw_we = 1'b0; seen_addr = '0; got_err = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (mem_en) begin en_cnt++; saw_we = mem_we; seen_addr = mem_addr; end
      if (cpu_ready) begin got = 1'b1; got_err = cpu_err; end
    end
    cpu_req = 1'b0;
    chk("txn_ready_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
  endtask

  // Abandon a read after `edges` clock edges; reset lands between edges.
  task automatic reset_mid(input int edges, input string tag);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0002;
    repeat (edges) @(posedge clk);
    #2;
    chk({tag, "_busy_before"}, 32'(busy), 32'd1);
    chk({tag, "_en_before"}, 32'(mem_en), (edges == 1) ? 32'd1 : 32'd0);
    reset = 1'b1;
    #1;
    chk({tag, "_en_async"}, 32'(mem_en), 32'd0);
    chk({tag, "_we_async"}, 32'(mem_we), 32'd0);
    chk({tag, "_busy_async"}, 32'(busy), 32'd0);
    chk({tag, "_ready_async"}, 32'(cpu_ready), 32'd0);
    cpu_req = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    quiet = 0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_ready || mem_en) quiet++;
    end
    chk({tag, "_no_ready_after"}, 32'(quiet), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'h0010, 32'h0,         1'b0, 32'hDEADBEEF, 4, 1};
    vecs[1] = '{1'b1, 16'h0003, 32'h12345678,  1'b0, 32'hDEADBEEF, 4, 1};
    vecs[2] = '{1'b0, 16'h0003, 32'h0,         1'b0, 32'h12345678, 4, 1};
    vecs[3] = '{1'b0, 16'h0400, 32'h0,         1'b1, 32'h12345678, 1, 0};
    vecs[4] = '{1'b1, 16'hFFFF, 32'hBAD0BAD0,  1'b1, 32'h12345678, 1, 0};
    vecs[5] = '{1'b0, 16'h03FF, 32'h0,         1'b0, 32'h55AA55AA, 4, 1};
    vecs[6] = '{1'b0, 16'h0001, 32'h0,         1'b0, 32'h0000000A, 4, 1};

    // Reset values, checked while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(cpu_ready), 32'd0);
    chk("rst_err", 32'(cpu_err), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_en", 32'(mem_en), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    preload(10'h010, 32'hDEADBEEF);
    preload(10'h001, 32'h0000000A);
    preload(10'h002, 32'h0000000B);
    preload(10'h3FF, 32'h55AA55AA);

    for (int i = 0; i < 7; i++) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("v%0d_edges", i), 32'(n), 32'(vecs[i].edges));
      chk($sformatf("v%0d_err", i), 32'(got_err), 32'(vecs[i].err));
      chk($sformatf("v%0d_rdata", i), cpu_rdata, vecs[i].rdata);
      chk($sformatf("v%0d_strobes", i), 32'(en_cnt), 32'(vecs[i].en));
      if (vecs[i].en != 0) begin
        chk($sformatf("v%0d_mem_we", i), 32'(saw_we), 32'(vecs[i].we));
        chk($sformatf("v%0d_mem_addr", i), 32'(seen_addr), 32'(vecs[i].addr));
      end
    end

    // Back-to-back reads with req held; address switched on ready.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001;
    n = 0; r1 = -1; r2 = -1; en_cnt = 0;
    while (r2 < 0 && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (mem_en) en_cnt++;
      if (cpu_ready) begin
        if (r1 < 0) begin
          r1 = n; chk("b2b_rdata1", cpu_rdata, 32'h0000000A); cpu_addr = 16'h0002;
        end else begin
          r2 = n; chk("b2b_rdata2", cpu_rdata, 32'h0000000B); cpu_req = 1'b0;
        end
      end
    end
    cpu_req = 1'b0;
    chk("b2b_second_ready_seen", 32'(r2 >= 0), 32'd1);
    chk("b2b_ready_spacing", 32'(r2 - r1), 32'd5);
    @(posedge clk); #1;
    repeat (3) begin @(negedge clk); if (mem_en) en_cnt++; end
    chk("b2b_strobes", 32'(en_cnt), 32'd2);
    @(posedge clk); #1;

    // Reset during ACCESS and during WAIT, then a normal read.
    reset_mid(1, "rst_access");
    reset_mid(2, "rst_wait");
    chk("rst_mid_rdata_cleared", cpu_rdata, 32'd0);
    txn(1'b0, 16'h0010, 32'h0);
    chk("post_rst_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("post_rst_edges", 32'(n), 32'd4);

    // Latency extremes: WAIT_CYCLES=1 -> 3 edges, WAIT_CYCLES=15 -> 17 edges.
    req_a = 1'b1; req_b = 1'b1;
    n = 0; la = -1; lb = -1; ena = 0; enb = 0;
    while ((la < 0 || lb < 0) && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (en_a) begin ena++; chk("w1_mem_addr", 32'(addr_a), 32'h1234); end
      if (en_b) begin enb++; chk("w15_we", 32'(we_b), 32'd0); end
      if (ready_a && la < 0) begin
        la = n; req_a = 1'b0;
        chk("w1_rdata", rdata_a, 32'h1111_0001);
        chk("w1_err", 32'(err_a), 32'd0);
      end
      if (ready_b && lb < 0) begin
        lb = n; req_b = 1'b0;
        chk("w15_rdata", rdata_b, 32'h1515_000F);
        chk("w15_err", 32'(err_b), 32'd0);
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    chk("w1_latency", 32'(la), 32'd3);
    chk("w15_latency", 32'(lb), 32'd17);
    chk("w1_strobes", 32'(ena), 32'd1);
    chk("w15_strobes", 32'(enb), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_idle_busy", 32'({busy_a, busy_b}), 32'd0);
    chk("lat_wdata_latched", wdata_a ^ wdata_b, 32'h0000_00FF);
    chk("lat_w1_we", 32'(we_a), 32'd0);
    chk("lat_w15_addr", 32'(addr_b), 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
